// File: rtl/iot_monitor_array.sv
// Multi-channel up/down device population counters with a registered
// aggregate total and a hysteretic over-population alarm.
module iot_monitor_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int TW      = WIDTH + $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       change,
    input  logic [CHANNELS-1:0]       on_off,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [TW-1:0]             hi_thresh,
    input  logic [TW-1:0]             lo_thresh,
    output logic [CHANNELS*WIDTH-1:0] counter_out,
    output logic [CHANNELS-1:0]       err_flag,
    output logic [TW-1:0]             total_out,
    output logic                      alarm
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            err_q, err_d;
    logic [TW-1:0]                  total_q, total_d;
    logic                           alarm_q, alarm_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                cnt_d[i] = '0;
                err_d[i] = 1'b0;
            end else if (change[i] && on_off[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    err_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end else if (change[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? '0 : CNT_MAX;
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end
        end
    end

    // Total is one stage behind the counters, alarm one stage behind the total
    always_comb begin
        total_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            total_d = total_d + TW'(cnt_q[i]);
        end
        if (total_q >= hi_thresh) begin
            alarm_d = 1'b1;
        end else if (total_q <= lo_thresh) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            err_q   <= '0;
            total_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            total_q <= total_d;
            alarm_q <= alarm_d;
        end
    end

    assign counter_out = cnt_q;
    assign err_flag    = err_q;
    assign total_out   = total_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_iot_monitor_array.sv
// Randomised and directed bench for iot_monitor_array, wrap and saturate
// variants side by side against an arithmetic reference model.
module tb_iot_monitor_array;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int TW = 10;
    localparam int MX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [C-1:0]    change, on_off, clear;
    logic [TW-1:0]   hi, lo;
    logic [C*W-1:0]  cnt_w, cnt_s;
    logic [C-1:0]    err_w, err_s;
    logic [TW-1:0]   tot_w, tot_s;
    logic            al_w, al_s;

    iot_monitor_array #(.WIDTH(W), .CHANNELS(C), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clear(clear), .hi_thresh(hi), .lo_thresh(lo),
        .counter_out(cnt_w), .err_flag(err_w),
        .total_out(tot_w), .alarm(al_w)
    );

    iot_monitor_array #(.WIDTH(W), .CHANNELS(C), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clear(clear), .hi_thresh(hi), .lo_thresh(lo),
        .counter_out(cnt_s), .err_flag(err_s),
        .total_out(tot_s), .alarm(al_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: index 0 = wrap variant, 1 = saturate variant
    int mc[2][C];
    bit me[2][C];
    int mt[2];
    bit ma[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    function automatic int get_cnt(input int s, input int i);
        logic [C*W-1:0] v;
        v = (s != 0) ? cnt_s : cnt_w;
        return int'(v[i*W +: W]);
    endfunction

    task automatic model_step();
        for (int s = 0; s < 2; s++) begin
            int sum;
            bit na;
            if (mt[s] >= int'(hi)) na = 1'b1;
            else if (mt[s] <= int'(lo)) na = 1'b0;
            else na = ma[s];
            sum = 0;
            for (int i = 0; i < C; i++) sum += mc[s][i];
            for (int i = 0; i < C; i++) begin
                if (clear[i]) begin
                    mc[s][i] = 0;
                    me[s][i] = 1'b0;
                end else if (change[i]) begin
                    int nv;
                    nv = mc[s][i] + (on_off[i] ? 1 : -1);
                    if (nv > MX || nv < 0) begin
                        me[s][i] = 1'b1;
                        if (s == 1) nv = (nv > MX) ? MX : 0;
                        else nv = (nv + MX + 1) % (MX + 1);
                    end
                    mc[s][i] = nv;
                end
            end
            mt[s] = sum;
            ma[s] = na;
            if (rst) begin
                for (int i = 0; i < C; i++) begin
                    mc[s][i] = 0;
                    me[s][i] = 1'b0;
                end
                mt[s] = 0;
                ma[s] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < C; i++) begin
                chk(s ? "cnt_sat" : "cnt_wrap", get_cnt(s, i), mc[s][i]);
                chk(s ? "err_sat" : "err_wrap",
                    s ? err_s[i] : err_w[i], me[s][i]);
            end
            chk(s ? "tot_sat" : "tot_wrap", s ? tot_s : tot_w, mt[s]);
            chk(s ? "alarm_sat" : "alarm_wrap", s ? al_s : al_w, ma[s]);
        end
    endtask

    task automatic cycle(input logic r, input logic [C-1:0] ch,
                         input logic [C-1:0] oo, input logic [C-1:0] cl);
        @(negedge clk);
        rst = r;
        change = ch;
        on_off = oo;
        clear = cl;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0);
    endtask

    task automatic up(input int ch, input int n);
        logic [C-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        for (int k = 0; k < n; k++) cycle(1'b0, m, m, '0);
    endtask

    task automatic down(input int ch, input int n);
        logic [C-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        for (int k = 0; k < n; k++) cycle(1'b0, m, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        change = '0;
        on_off = '0;
        clear = '0;
        hi = TW'(20);
        lo = TW'(10);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < C; i++) begin
                mc[s][i] = 0;
                me[s][i] = 1'b0;
            end
            mt[s] = 0;
            ma[s] = 1'b0;
        end

        // reset and hold, on_off toggling with change low
        cycle(1'b1, '0, '0, '0);
        cycle(1'b1, '0, '0, '0);
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, (k % 2) ? '1 : '0, '0);
        chk("hold_tot", tot_w, 0);
        chk("hold_cnt", cnt_w, 0);

        // up/down and total latency
        up(0, 5);
        up(1, 3);
        down(1, 1);
        chk("ch0_5", get_cnt(0, 0), 5);
        chk("ch1_2", get_cnt(0, 1), 2);
        chk("tot_pre", tot_w, 8);
        idle(1);
        chk("tot_7", tot_w, 7);
        chk("err_none", err_w, 0);

        // wrap vs saturate at zero and at max
        down(2, 1);
        chk("wrap_255", get_cnt(0, 2), 255);
        chk("sat_0", get_cnt(1, 2), 0);
        chk("sat_err", err_s[2], 1);
        up(2, 1);
        chk("wrap_0", get_cnt(0, 2), 0);
        chk("wrap_err", err_w[2], 1);
        cycle(1'b0, '0, '0, 4'b0100);
        up(2, 255);
        chk("sat_255", get_cnt(1, 2), 255);
        chk("sat_noerr", err_s[2], 0);
        up(2, 1);
        chk("sat_hold", get_cnt(1, 2), 255);
        chk("sat_err256", err_s[2], 1);

        // clear beats a simultaneous change
        cycle(1'b0, '0, '0, 4'b1000);
        down(3, 1);
        up(3, 11);
        chk("ch3_10", get_cnt(0, 3), 10);
        chk("ch3_err", err_w[3], 1);
        cycle(1'b0, 4'b1000, 4'b1000, 4'b1000);
        chk("clr_cnt", get_cnt(0, 3), 0);
        chk("clr_err", err_w[3], 0);
        chk("clr_other", get_cnt(0, 0), 5);

        // hysteresis, hi=20 lo=10
        cycle(1'b0, '0, '0, '1);
        idle(3);
        up(0, 19);
        idle(3);
        chk("hys_19", al_w, 0);
        up(0, 1);
        idle(1);
        chk("hys_tot20", tot_w, 20);
        chk("hys_lag", al_w, 0);
        idle(1);
        chk("hys_set", al_w, 1);
        down(0, 5);
        idle(3);
        chk("hys_15", al_w, 1);
        down(0, 5);
        idle(3);
        chk("hys_10", al_w, 0);
        up(0, 5);
        idle(3);
        chk("hys_up15", al_w, 0);

        // reset mid-run with change on every channel
        up(0, 10);
        idle(3);
        chk("pre_rst_al", al_w, 1);
        cycle(1'b1, '1, '1, '0);
        chk("rst_cnt", cnt_w, 0);
        chk("rst_tot", tot_w, 0);
        chk("rst_al", al_w, 0);
        cycle(1'b0, '1, '1, '0);
        chk("resume_ch0", get_cnt(0, 0), 1);
        chk("resume_tot", tot_w, 0);
        chk("resume_al", al_w, 0);

        // random traffic with live thresholds
        for (int k = 0; k < 3000; k++) begin
            logic [C-1:0] ch, oo, cl;
            logic r;
            ch = C'($urandom);
            oo = C'($urandom);
            cl = '0;
            for (int i = 0; i < C; i++) cl[i] = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            if ((k % 50) == 0) begin
                hi = TW'($urandom_range(0, 600));
                lo = TW'($urandom_range(0, 600));
            end
            cycle(r, ch, oo, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
